// File: rtl/lut_neuron_bank_if.sv
// lut_neuron_bank_if
// Streaming data-path bundle for the LUT neuron bank.
//   in_valid / in_ready / in_data    : input words, one packed address per neuron
//   out_valid / out_ready / out_data : results, one packed activation per neuron
// master : the upstream/downstream side (drives inputs, accepts results)
// slave  : the neuron bank itself
interface lut_neuron_bank_if #(
  parameter int NUM_NEURONS = 4,
  parameter int ADDR_W      = 6,
  parameter int OUT_BITS    = 2
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_NEURONS*ADDR_W-1:0]   in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_neuron_bank.sv
// lut_neuron_bank
// Runtime-loadable bank of LogicNet LUT neurons. Each neuron owns a truth
// table of 2^ADDR_W entries of OUT_BITS; a two-stage valid/ready pipeline
// looks up every neuron in parallel. Tables are written through the cfg port
// while the bank sits in LOAD; RUN streams inferences; DRAIN empties the
// pipeline before handing control back to LOAD.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   io (slave)      : in_valid/in_ready/in_data, out_valid/out_ready/out_data
//   cfg_mode        : 1 requests LOAD, 0 requests RUN
//   cfg_we/neuron/addr/data : table write request
//   cfg_ack/cfg_err : one-cycle write accepted / rejected pulses
//   state           : 00 LOAD, 01 RUN, 10 DRAIN
//   loaded          : per-neuron table-complete flags
module lut_neuron_bank #(
  parameter int  FAN_IN      = 3,
  parameter int  IN_BITS     = 2,
  parameter int  OUT_BITS    = 2,
  parameter int  NUM_NEURONS = 4,
  localparam int ADDR_W      = FAN_IN * IN_BITS,
  localparam int NEURON_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lut_neuron_bank_if.slave       io,
  input  logic                   cfg_mode,
  input  logic                   cfg_we,
  input  logic [NEURON_W-1:0]    cfg_neuron,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [OUT_BITS-1:0]    cfg_data,
  output logic                   cfg_ack,
  output logic                   cfg_err,
  output logic [1:0]             state,
  output logic [NUM_NEURONS-1:0] loaded
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  state_t state_r, state_nxt;

  logic [OUT_BITS-1:0]             table_mem [NUM_NEURONS][DEPTH];
  logic [NUM_NEURONS-1:0]          loaded_r;
  logic                            cfg_ack_r;
  logic                            cfg_err_r;

  logic                            s1_valid_r;
  logic [NUM_NEURONS*ADDR_W-1:0]   s1_data_r;
  logic                            s2_valid_r;
  logic [NUM_NEURONS*OUT_BITS-1:0] s2_data_r;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup_s;

  logic stall_s;
  logic in_ready_s;
  logic in_hs_s;
  logic nrn_ok_s;
  logic wr_ok_s;
  logic wr_bad_s;

  // The neuron range check only exists when the select field can encode
  // indices beyond the bank.
  generate
    if ((1 << NEURON_W) == NUM_NEURONS) begin : g_nrn_full
      assign nrn_ok_s = 1'b1;
    end else begin : g_nrn_part
      assign nrn_ok_s = ({1'b0, cfg_neuron} < (NEURON_W + 1)'(NUM_NEURONS));
    end
  endgenerate

  assign stall_s = s2_valid_r & ~io.out_ready;
  assign in_hs_s = io.in_valid & in_ready_s;

  // Next-state and mode-dependent controls: ready, write accept/reject.
  always_comb begin
    state_nxt  = state_r;
    in_ready_s = 1'b0;
    wr_ok_s    = 1'b0;
    wr_bad_s   = 1'b0;
    case (state_r)
      ST_LOAD: begin
        wr_ok_s  = cfg_we & nrn_ok_s;
        wr_bad_s = cfg_we & ~nrn_ok_s;
        // A pending write keeps the bank in LOAD even if RUN is requested.
        if (!cfg_mode && !cfg_we) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_RUN: begin
        wr_bad_s = cfg_we;
        // S1 may take a word while S2 is stalled only if S1 is empty.
        in_ready_s = ~stall_s | ~s1_valid_r;
        if (cfg_mode) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        wr_bad_s = cfg_we;
        if (!s1_valid_r && !s2_valid_r) begin
          state_nxt = ST_LOAD;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  // Mode register, config handshake pulses and loaded flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_LOAD;
      cfg_ack_r <= 1'b0;
      cfg_err_r <= 1'b0;
      loaded_r  <= {NUM_NEURONS{1'b0}};
    end else begin
      state_r   <= state_nxt;
      cfg_ack_r <= wr_ok_s;
      cfg_err_r <= wr_bad_s;
      // Loaders write ascending, so the last entry marks the table complete;
      // any earlier entry means a reload has started.
      if (wr_ok_s) begin
        loaded_r[cfg_neuron] <= &cfg_addr;
      end
    end
  end

  // Truth-table storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok_s) begin
      table_mem[cfg_neuron][cfg_addr] <= cfg_data;
    end
  end

  // Parallel lookup of every neuron from the S1 address word.
  generate
    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lookup
      assign lookup_s[g*OUT_BITS +: OUT_BITS] =
        loaded_r[g] ? table_mem[g][s1_data_r[g*ADDR_W +: ADDR_W]]
                    : {OUT_BITS{1'b0}};
    end
  endgenerate

  // S1 address capture; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    if (in_hs_s) begin
      s1_data_r <= io.in_data;
    end
  end

  // Pipeline valids and S2 result register; a stall freezes both stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_data_r  <= {(NUM_NEURONS*OUT_BITS){1'b0}};
    end else begin
      s1_valid_r <= in_hs_s | (s1_valid_r & stall_s);
      if (!stall_s) begin
        s2_valid_r <= s1_valid_r;
        // out_data keeps its last value across bubbles.
        if (s1_valid_r) begin
          s2_data_r <= lookup_s;
        end
      end
    end
  end

  assign io.in_ready  = in_ready_s;
  assign io.out_valid = s2_valid_r;
  assign io.out_data  = s2_data_r;
  assign cfg_ack      = cfg_ack_r;
  assign cfg_err      = cfg_err_r;
  assign state        = state_r;
  assign loaded       = loaded_r;

endmodule

// File: tb/tb_lut_neuron_bank.sv
// tb_lut_neuron_bank
// Randomised scoreboard bench: a behavioural model (tables, loaded flags,
// mode, in-flight queue) predicts every result, mode, ack/err and ready.
module tb_lut_neuron_bank;
  localparam int NN    = 4;
  localparam int AW    = 6;
  localparam int OB    = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_mode;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [5:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_ack;
  logic        cfg_err;
  logic [1:0]  state;
  logic [3:0]  loaded;

  lut_neuron_bank_if #(.NUM_NEURONS(NN), .ADDR_W(AW), .OUT_BITS(OB)) bus ();

  lut_neuron_bank #(
    .FAN_IN(3), .IN_BITS(2), .OUT_BITS(OB), .NUM_NEURONS(NN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(bus),
    .cfg_mode(cfg_mode), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .cfg_err(cfg_err), .state(state), .loaded(loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [1:0] m_tbl [NN][DEPTH];
  bit   [3:0] m_loaded;
  int         m_state;          // 0 LOAD, 1 RUN, 2 DRAIN
  bit         m_ack, m_err;
  bit         m_live = 1'b0;
  bit         prev_stall, just_reset;
  logic [7:0] prev_od;
  logic [7:0] sb_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_out(input logic [23:0] d);
    logic [7:0] r;
    logic [5:0] a;
    r = 8'h00;
    for (int n = 0; n < NN; n++) begin
      a = d[n*AW +: AW];
      r[n*OB +: OB] = m_loaded[n] ? m_tbl[n][a] : 2'b00;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state    = 0;
    m_loaded   = 4'b0000;
    m_ack      = 1'b0;
    m_err      = 1'b0;
    sb_q.delete();
    prev_stall = 1'b0;
    just_reset = 1'b1;
    prev_od    = 8'h00;
  endtask

  // Monitor: checks DUT against the model, then advances the model one edge.
  initial begin : monitor
    int         qsz;
    logic       stall;
    logic [7:0] e;
    bit         wok;
    forever begin
      @(negedge clk);
      if (m_live) begin
        qsz   = sb_q.size();
        stall = bus.out_valid & ~bus.out_ready;
        chk("state", 32'(state), 32'(m_state));
        chk("loaded", 32'(loaded), 32'(m_loaded));
        chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        if (m_state == 1) chk("in_ready_run", 32'(bus.in_ready), 32'(!stall || qsz < 2));
        else              chk("in_ready_idle", 32'(bus.in_ready), 32'd0);
        if (qsz == 0) chk("out_valid_empty", 32'(bus.out_valid), 32'd0);
        if (just_reset) begin
          chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
          chk("rst_out_data", 32'(bus.out_data), 32'd0);
        end else if (prev_stall) begin
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_data", 32'(bus.out_data), 32'(prev_od));
        end else if (!bus.out_valid) begin
          chk("idle_hold", 32'(bus.out_data), 32'(prev_od));
        end
        if (rst_n) begin
          wok   = (m_state == 0) && cfg_we && (cfg_neuron < 2'(NN - 1)) || (m_state == 0) && cfg_we && (cfg_neuron == 2'(NN - 1));
          m_ack = wok;
          m_err = cfg_we && !wok;
          if (wok) begin
            m_tbl[cfg_neuron][cfg_addr] = cfg_data;
            m_loaded[cfg_neuron] = (cfg_addr == 6'd63);
          end
          case (m_state)
            0:       if (!cfg_mode && !cfg_we) m_state = 1;
            1:       if (cfg_mode) m_state = 2;
            2:       if (qsz == 0) m_state = 0;
            default: m_state = 0;
          endcase
          if (bus.out_valid && bus.out_ready && qsz > 0) begin
            e = sb_q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e));
          end
          if (bus.in_valid && bus.in_ready) sb_q.push_back(ref_out(bus.in_data));
          prev_stall = stall;
          prev_od    = bus.out_data;
          just_reset = 1'b0;
        end else begin
          model_reset();
        end
      end else if (!rst_n) begin
        model_reset();
        m_live = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int k = 0;
    while (state !== s && k < 50) begin
      tick();
      k++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  task automatic drain();
    int k = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic stream(input int nw, input int st, input int sl, input bit rnd);
    int sent = 0;
    int cyc  = 0;
    bit acc  = 1'b1;
    while (sent < nw && cyc < 3000) begin
      if (acc) bus.in_data = 24'($urandom);
      bus.in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= st && cyc < st + sl);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) sent++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'(nw));
  endtask

  task automatic one_word(input logic [23:0] w, output logic [7:0] od, output int lat);
    bit v = 1'b0;
    bus.in_data = w; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("one_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    od  = 8'h00;
    while (!v && lat < 10) begin
      @(negedge clk);
      v  = bus.out_valid;
      od = bus.out_data;
      @(posedge clk);
      lat++;
    end
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] od;
    logic [5:0] aa;
    int         lat;
    rst_n = 1'b0; cfg_mode = 1'b1; cfg_we = 1'b0; cfg_neuron = 2'd0;
    cfg_addr = 6'd0; cfg_data = 2'd0;
    bus.in_valid = 1'b1; bus.in_data = 24'h000002; bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    bus.in_valid = 1'b0;

    // neuron 0: 2'b11 where addr[1:0]==2'b10
    for (int a = 0; a < DEPTH; a++) begin
      aa = 6'(a);
      wr(2'd0, aa, (aa[1:0] == 2'b10) ? 2'b11 : 2'b00);
    end
    // neuron 1: complete, then reopened by a low write -> not loaded
    for (int a = 0; a < DEPTH; a++) wr(2'd1, 6'(a), 2'b01);
    wr(2'd1, 6'd5, 2'b10);
    // neuron 2: random contents
    for (int a = 0; a < DEPTH; a++) wr(2'd2, 6'(a), 2'($urandom));
    chk("loaded_after_load", 32'(loaded), 32'h5);

    cfg_mode = 1'b0;
    wait_state(2'b01, "enter_run");

    one_word({18'($urandom), 6'b000010}, od, lat);
    chk("latency", 32'(lat), 32'd2);
    chk("n0_hit", 32'(od[1:0]), 32'h3);
    chk("n1_unloaded", 32'(od[3:2]), 32'h0);
    chk("n3_unloaded", 32'(od[7:6]), 32'h0);
    one_word({18'($urandom), 6'b000101}, od, lat);
    chk("n0_miss", 32'(od[1:0]), 32'h0);

    // rejected write in RUN must not disturb the table
    wr(2'd0, 6'd2, 2'b00);
    tick();
    one_word({18'($urandom), 6'b000010}, od, lat);
    chk("n0_after_rejected", 32'(od[1:0]), 32'h3);

    stream(150, 0, 0, 1'b1);
    drain();
    stream(8, 3, 4, 1'b0);
    drain();

    // mode switch with two words in flight
    bus.in_valid = 1'b1; bus.in_data = 24'($urandom); bus.out_ready = 1'b1;
    tick();
    bus.in_data = 24'($urandom); cfg_mode = 1'b1;
    tick();
    chk("drain_state", 32'(state), 32'd2);
    bus.in_data = 24'($urandom);
    wr(2'd3, 6'd0, 2'b11);
    wait_state(2'b00, "drain_to_load");
    bus.in_valid = 1'b0;
    drain();

    // reset while stalled
    cfg_mode = 1'b0;
    wait_state(2'b01, "rerun");
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    repeat (3) begin
      bus.in_data = 24'($urandom);
      tick();
    end
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0; bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_loaded", 32'(loaded), 32'd0);
    bus.out_ready = 1'b1;
    wait_state(2'b01, "run_after_rst");
    one_word({18'($urandom), 6'b000010}, od, lat);
    chk("n0_after_rst", 32'(od), 32'h00);
    stream(12, 0, 0, 1'b0);
    drain();
    repeat (3) tick();
    chk("final_queue", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
